// File: rtl/fetch_unit.sv
// fetch_unit: in-order instruction fetch with a credit-limited prefetch queue and redirect flush
module fetch_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h00000000
) (
  input  logic        clock,
  input  logic        Reset,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  input  logic        out_ready
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;
  state_t state, state_n;
  logic [31:0] fetch_pc;
  logic [CW-1:0] count, outstanding, stale, stale_n;
  logic [AW-1:0] q_head, q_tail, p_head, p_tail;
  logic [31:0] q_instr [DEPTH];
  logic [31:0] q_pc [DEPTH];
  logic [31:0] p_addr [DEPTH];
  logic accept, resp_any, resp_live, pop, flush;
  // credit: in-flight requests plus queued words never exceed DEPTH, so the queue cannot overflow
  assign imem_req_valid = state == FETCH && (outstanding + count < CW'(DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign accept    = imem_req_valid & imem_req_ready;
  assign resp_any  = imem_resp_valid && (stale != '0 || outstanding != '0);
  assign resp_live = imem_resp_valid && stale == '0 && outstanding != '0;
  assign out_valid = count != '0;
  assign out_instr = out_valid ? q_instr[q_head] : '0;
  assign out_pc    = out_valid ? q_pc[q_head] : '0;
  assign pop       = out_valid & out_ready;
  assign flush     = redirect_valid && state != IDLE;
  // everything still owed by memory after a redirect belongs to the old stream
  assign stale_n   = stale + outstanding + CW'(accept) - CW'(resp_any);
  always_comb begin
    state_n = state == IDLE ? FETCH :
              flush ? (stale_n != '0 ? DRAIN : FETCH) :
              (state == DRAIN && stale == '0) ? FETCH : state;
  end
  always_ff @(posedge clock or posedge Reset) begin
    if (Reset) begin
      state       <= IDLE;
      fetch_pc    <= RESET_PC;
      count       <= '0;
      outstanding <= '0;
      stale       <= '0;
      q_head      <= '0;
      q_tail      <= '0;
      p_head      <= '0;
      p_tail      <= '0;
    end else begin
      state <= state_n;
      if (flush) begin
        fetch_pc    <= {redirect_pc[31:2], 2'b00};
        count       <= '0;
        outstanding <= '0;
        stale       <= stale_n;
        q_head      <= '0;
        q_tail      <= '0;
        p_head      <= '0;
        p_tail      <= '0;
      end else begin
        if (accept) begin
          fetch_pc <= fetch_pc + 32'd4;
          p_tail   <= p_tail + 1'b1;
        end
        if (resp_live) begin
          p_head <= p_head + 1'b1;
          q_tail <= q_tail + 1'b1;
        end
        if (pop) q_head <= q_head + 1'b1;
        count       <= count + CW'(resp_live) - CW'(pop);
        outstanding <= outstanding + CW'(accept) - CW'(resp_live);
        stale       <= stale - CW'(imem_resp_valid && stale != '0);
      end
    end
  end
  always_ff @(posedge clock) begin
    if (accept && !flush) p_addr[p_tail] <= fetch_pc;
    if (resp_live && !flush) begin
      q_pc[q_tail]    <= p_addr[p_head];
      q_instr[q_tail] <= imem_resp_data;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized fetch traffic against an epoch-based reference model
module tb_fetch_unit;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h00000000;
  localparam logic [31:0] KEY      = 32'hA5A50000;
  logic        clock = 0;
  logic        Reset = 1;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready = 0;
  logic        imem_resp_valid = 0;
  logic [31:0] imem_resp_data = 0;
  logic        redirect_valid = 0;
  logic [31:0] redirect_pc = 0;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_ready = 0;
  fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clock(clock), .Reset(Reset),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc), .out_ready(out_ready)
  );
  always #5 clock = ~clock;
  int n_chk = 0;
  int n_pass = 0;
  task chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
  endtask
  typedef struct {logic [31:0] addr; int due;} mreq_t;
  mreq_t mq[$];
  int cyc = 0;
  int last_due = 0;
  int lat_lo = 1, lat_hi = 1;
  int rdy_pct = 100, ordy_pct = 100, redir_pct = 0;
  logic [31:0] m_fetch = RESET_PC;
  logic [31:0] m_pend[$];
  logic [31:0] m_q[$];
  int cur_out = 0, old_out = 0;
  bit m_started = 0, m_drain = 0;
  bit exp_ov, exp_rv, acc, rsp, pop;
  int due;
  always @(negedge clock) begin
    if (Reset) begin
      chk("rst_out_valid", out_valid, 0);
      chk("rst_req_valid", imem_req_valid, 0);
      chk("rst_req_addr", imem_req_addr, RESET_PC);
      chk("rst_out_pc", out_pc, 0);
      chk("rst_out_instr", out_instr, 0);
      m_fetch = RESET_PC;
      cur_out = 0;
      old_out = 0;
      m_pend.delete();
      m_q.delete();
      m_started = 0;
      m_drain = 0;
      mq.delete();
      last_due = 0;
    end else begin
      exp_ov = m_q.size() != 0;
      exp_rv = m_started && !m_drain && (cur_out + m_q.size() < DEPTH);
      chk("out_valid", out_valid, exp_ov);
      if (exp_ov) begin
        chk("out_pc", out_pc, m_q[0]);
        chk("out_instr", out_instr, m_q[0] ^ KEY);
      end
      chk("req_valid", imem_req_valid, exp_rv);
      if (exp_rv) chk("req_addr", imem_req_addr, m_fetch);
      if (imem_req_valid && imem_req_ready) begin
        due = cyc + $urandom_range(lat_hi, lat_lo);
        if (due < last_due) due = last_due;
        last_due = due;
        mq.push_back('{imem_req_addr, due});
      end
      acc = exp_rv && imem_req_ready;
      rsp = imem_resp_valid;
      pop = exp_ov && out_ready;
      if (redirect_valid && m_started) begin
        old_out = old_out + cur_out + (acc ? 1 : 0) - ((rsp && old_out + cur_out > 0) ? 1 : 0);
        cur_out = 0;
        m_pend.delete();
        m_q.delete();
        m_fetch = redirect_pc & 32'hFFFFFFFC;
        m_drain = old_out > 0;
      end else begin
        m_started = 1;
        if (m_drain && old_out == 0) m_drain = 0;
        if (pop) void'(m_q.pop_front());
        if (rsp && old_out > 0) old_out--;
        else if (rsp && cur_out > 0 && m_pend.size() > 0) begin
          cur_out--;
          m_q.push_back(m_pend.pop_front());
        end
        if (acc) begin
          m_pend.push_back(m_fetch);
          cur_out++;
          m_fetch = m_fetch + 32'd4;
        end
      end
    end
    cyc++;
  end
  task tick();
    @(posedge clock);
    #1;
    if (!Reset && mq.size() != 0 && mq[0].due <= cyc) begin
      imem_resp_valid = 1;
      imem_resp_data  = mq[0].addr ^ KEY;
      void'(mq.pop_front());
    end else begin
      imem_resp_valid = 0;
      imem_resp_data  = $urandom;
    end
    imem_req_ready = $urandom_range(99) < rdy_pct;
    out_ready      = $urandom_range(99) < ordy_pct;
    redirect_valid = $urandom_range(99) < redir_pct;
    redirect_pc    = $urandom;
  endtask
  initial begin
    int n;
    bit found;
    repeat (3) tick();
    Reset = 0;
    n = 0;
    while (!out_valid && n < 10) begin
      tick();
      n++;
    end
    chk("first_valid_latency", n, 3);
    repeat (20) tick();
    ordy_pct = 0;
    repeat (12) tick();
    chk("bp_req_stalled", imem_req_valid, 0);
    chk("bp_queue_full", out_valid, 1);
    ordy_pct = 100;
    repeat (10) tick();
    lat_lo = 3;
    lat_hi = 3;
    repeat (10) tick();
    tick();
    redirect_valid = 1;
    redirect_pc    = 32'h00000043;
    tick();
    chk("redir_flush", out_valid, 0);
    repeat (20) tick();
    lat_lo = 1;
    lat_hi = 2;
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      tick();
      if (imem_req_valid && imem_resp_valid && out_valid) begin
        redirect_valid = 1;
        redirect_pc    = 32'h00000200;
        found = 1;
      end
    end
    chk("simul_found", found, 1);
    repeat (20) tick();
    tick();
    redirect_valid = 1;
    redirect_pc    = 32'hFFFFFFF8;
    repeat (15) tick();
    lat_lo = 1;
    lat_hi = 4;
    rdy_pct = 70;
    ordy_pct = 60;
    redir_pct = 4;
    repeat (3000) tick();
    lat_lo = 1;
    lat_hi = 1;
    rdy_pct = 100;
    ordy_pct = 0;
    redir_pct = 0;
    found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      tick();
      found = m_q.size() == 3 && !m_drain;
    end
    chk("mid_rst_count3", found, 1);
    chk("pre_rst_valid", out_valid, 1);
    #2;
    Reset = 1;
    #1;
    chk("async_out_valid", out_valid, 0);
    chk("async_req_valid", imem_req_valid, 0);
    repeat (2) tick();
    Reset = 0;
    ordy_pct = 100;
    repeat (25) tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage that feeds the single-cycle datapath with instruction words and their PCs. It issues in-order word requests to an instruction memory with variable latency and buffers returned words in a DEPTH-entry prefetch queue. The queue presents words to the datapath over a valid/ready handshake. Branch/jump redirects from the datapath flush the queue and discard responses already in flight.

Parameters:
DEPTH, 4, prefetch queue entries; also the maximum of outstanding requests plus queued words (power of 2, >=2)
RESET_PC, 32'h00000000, first fetch address after reset

Ports:
clock  input  1  system clock, rising edge
Reset  input  1  asynchronous, active-high reset
imem_req_valid  output  1  request to instruction memory
imem_req_addr  output  32  word address of request, bits [1:0] always 00
imem_req_ready  input  1  memory accepts request this cycle
imem_resp_valid  input  1  response word valid; responses return in request order
imem_resp_data  input  32  instruction word
redirect_valid  input  1  flush and restart fetch
redirect_pc  input  32  new fetch address; bits [1:0] ignored
out_valid  output  1  queue head valid
out_instr  output  32  queue head instruction
out_pc  output  32  PC of queue head
out_ready  input  1  datapath consumes head

Behaviour:
- Reset is asynchronous and active-high. While Reset is high: state=IDLE, fetch_pc=RESET_PC, queue empty, outstanding=0, stale=0, imem_req_valid=0, imem_req_addr=RESET_PC, out_valid=0, out_instr=0, out_pc=0.
- FSM states:
  - IDLE: one cycle after Reset deasserts, then FETCH.
  - FETCH: normal issue.
  - DRAIN: stale>0; no requests issued; returns to FETCH in the cycle after stale reaches 0.
- Issue rule, FETCH only: imem_req_valid=1 iff outstanding+count<DEPTH. imem_req_addr=fetch_pc.
  - On valid&ready: fetch_pc+=4, wrapping 0xFFFFFFFC->0x00000000, and fetch_pc is pushed onto a pending-address FIFO (DEPTH entries); outstanding+1.
  - Request withdrawal (valid dropping without ready) is permitted only on redirect or reset. Otherwise addr is held stable until accepted.
- Response: if stale>0, the response is discarded and stale-1. Otherwise the pending-address FIFO is popped and {pc,data} is written to the queue; outstanding-1.
  - Written word is visible at the outputs in the next cycle. Minimum request-to-out_valid latency is response latency +1.
  - A response arriving with outstanding=0 and stale=0 is ignored.
- Output: out_valid=(count!=0); out_instr/out_pc show the queue head. Head pops on out_valid&out_ready.
  - Pop and write in the same cycle keeps count unchanged.
  - Overflow is impossible by the credit rule; an underflow pop is a no-op.
- Redirect (highest priority, any state except IDLE), at the clock edge:
  - Queue and pending-address FIFO are cleared.
  - stale = outstanding, plus 1 if a request is accepted in the same cycle, minus 1 if a response arrives in the same cycle.
  - outstanding=0; fetch_pc={redirect_pc[31:2],2'b00}.
  - Next state is DRAIN if the new stale>0, else FETCH.
  - out_valid=0 in the next cycle.
  - A simultaneous out handshake is treated as consumed.
  - Redirect in DRAIN accumulates stale the same way.
- Counters: count, outstanding and stale are each clog2(DEPTH)+1 bits wide.
- Reset mid-operation: all state is discarded immediately. The memory is required to be reset by the same Reset.

Test Plan:
- Reset to stream: Reset held 3 cycles then released; ready=1, 1-cycle response latency, data=addr^0xA5A50000, out_ready=1 -> requests at 0x0,0x4,0x8,...; out_pc 0x0,0x4,0x8 back-to-back with matching out_instr; first out_valid 3 cycles after Reset falls.
- Backpressure: out_ready=0 -> exactly 4 requests (0x0-0xC) accepted, then imem_req_valid=0 and count=4; raise out_ready -> one pop per cycle, next request at 0x10 in the cycle after the first pop.
- Redirect with in-flight responses: 3-cycle response latency, 2 outstanding, redirect_pc=0x43 -> state DRAIN, next 2 responses dropped, out_valid stays 0, then requests resume at 0x40 and first out_pc=0x40.
- Simultaneous events: redirect asserted in the same cycle as a response, a request acceptance and an out handshake -> the response is discarded, the accepted request is counted stale, and no word from the old stream is ever presented.
- Wrap-around: redirect_pc=0xFFFFFFF8 -> out_pc sequence 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
- Reset mid-operation: assert Reset asynchronously (between edges) with queue count=3 -> out_valid and imem_req_valid drop immediately; after release, fetch restarts at RESET_PC.
